// File: rtl/tia_horizontal_decode_pkg.sv
// ============================================================================
// Module : tia_horizontal_decode_pkg
// Brief  : Shared LFSR step/index helpers, decode indices and types.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package tia_horizontal_decode_pkg;

  localparam int K_SHS  = 4;
  localparam int K_RHS  = 8;
  localparam int K_SCB  = 8;
  localparam int K_RCB  = 12;
  localparam int K_RHB  = 16;
  localparam int K_LRHB = 18;
  localparam int K_CNT  = 36;
  localparam int K_SHB  = 56;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_ERR   = 2'd2
  } chk_state_t;

  // SCB shares index 8 with RHS, so one bit covers both
  typedef struct packed {
    logic shs;
    logic rhs;
    logic rcb;
    logic rhb;
    logic lrhb;
    logic cnt;
    logic shb;
  } match_t;

  function automatic logic [5:0] lfsr_next(input logic [5:0] s);
    return {~(s[1] ^ s[0]), s[5:1]};
  endfunction

  function automatic logic [5:0] lfsr_at(input int k);
    logic [5:0] s;
    s = 6'd0;
    for (int i = 0; i < k; i++) s = lfsr_next(s);
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tia_horizontal_decode_if.sv
// ============================================================================
// Module : tia_horizontal_decode_if
// Brief  : Tick/strobe inputs and line-timing outputs of the horizontal decode.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface tia_horizontal_decode_if;
  logic       hclk_en;
  logic [5:0] lfsr_out;
  logic       hmove_stb;
  logic       rsyn;
  logic       hsync;
  logic       hblank;
  logic       cburst;
  logic       center;
  logic       shb;
  logic       late_hb;
  logic       seq_err;

  modport master (
    output hclk_en, lfsr_out, hmove_stb, rsyn,
    input  hsync, hblank, cburst, center, shb, late_hb, seq_err
  );

  modport slave (
    input  hclk_en, lfsr_out, hmove_stb, rsyn,
    output hsync, hblank, cburst, center, shb, late_hb, seq_err
  );
endinterface

`default_nettype wire

// File: rtl/tia_horizontal_match.sv
// ============================================================================
// Module : tia_horizontal_match
// Brief  : Combinational LFSR state -> one-hot decode match vector.
// Rev    : 1.0
// ============================================================================
`default_nettype none

import tia_horizontal_decode_pkg::*;

module tia_horizontal_match (
  input  logic [5:0] lfsr_out,
  output match_t     hit
);
  localparam logic [5:0] c_shs  = lfsr_at(K_SHS);
  localparam logic [5:0] c_rhs  = lfsr_at(K_RHS);
  localparam logic [5:0] c_rcb  = lfsr_at(K_RCB);
  localparam logic [5:0] c_rhb  = lfsr_at(K_RHB);
  localparam logic [5:0] c_lrhb = lfsr_at(K_LRHB);
  localparam logic [5:0] c_cnt  = lfsr_at(K_CNT);
  localparam logic [5:0] c_shb  = lfsr_at(K_SHB);

  always_comb begin
    hit      = '0;
    hit.shs  = (lfsr_out == c_shs);
    hit.rhs  = (lfsr_out == c_rhs);
    hit.rcb  = (lfsr_out == c_rcb);
    hit.rhb  = (lfsr_out == c_rhb);
    hit.lrhb = (lfsr_out == c_lrhb);
    hit.cnt  = (lfsr_out == c_cnt);
    hit.shb  = (lfsr_out == c_shb);
  end
endmodule

`default_nettype wire

// File: rtl/tia_horizontal_decode.sv
// ============================================================================
// Module : tia_horizontal_decode
// Brief  : Horizontal line-timing latches, HMOVE/RSYNC handling, LFSR checker.
// Rev    : 1.0
// ============================================================================
`default_nettype none

import tia_horizontal_decode_pkg::*;

module tia_horizontal_decode #(
  parameter bit CHECK_SEQ = 1'b1
) (
  input logic                    clk,
  input logic                    rstl,
  tia_horizontal_decode_if.slave hif
);
  match_t     w_hit;
  chk_state_t r_state;
  logic [5:0] r_expected;
  logic       r_hsync, r_hblank, r_cburst, r_center, r_shb, r_late_hb, r_seq_err;

  tia_horizontal_match u_match (
    .lfsr_out (hif.lfsr_out),
    .hit      (w_hit)
  );

  always_ff @(posedge clk or negedge rstl) begin
    if (!rstl) begin
      r_hsync    <= 1'b0;
      r_hblank   <= 1'b1;
      r_cburst   <= 1'b0;
      r_center   <= 1'b0;
      r_shb      <= 1'b0;
      r_late_hb  <= 1'b0;
      r_seq_err  <= 1'b0;
      r_expected <= 6'd0;
      r_state    <= ST_IDLE;
    end else if (hif.rsyn) begin
      // Forced line end: overrides any decode and check in the same cycle
      r_hsync    <= 1'b0;
      r_hblank   <= 1'b1;
      r_cburst   <= 1'b0;
      r_center   <= 1'b0;
      r_shb      <= 1'b1;
      r_late_hb  <= hif.hmove_stb;
      r_expected <= 6'd0;
    end else begin
      r_center <= 1'b0;
      r_shb    <= 1'b0;
      if (hif.hmove_stb)
        r_late_hb <= 1'b1;
      else if (hif.hclk_en && w_hit.shb)
        r_late_hb <= 1'b0;

      if (hif.hclk_en) begin
        if (w_hit.shs) r_hsync <= 1'b1;
        if (w_hit.rhs) begin
          r_hsync  <= 1'b0;
          r_cburst <= 1'b1;
        end
        if (w_hit.rcb) r_cburst <= 1'b0;
        if (w_hit.rhb && !r_late_hb) r_hblank <= 1'b0;
        if (w_hit.lrhb && r_late_hb) r_hblank <= 1'b0;
        if (w_hit.cnt) r_center <= 1'b1;
        if (w_hit.shb) begin
          r_hblank <= 1'b1;
          r_shb    <= 1'b1;
        end

        if (CHECK_SEQ) begin
          if (hif.lfsr_out != r_expected) begin
            // Resync on the observed value so one glitch logs one error
            r_seq_err  <= 1'b1;
            r_state    <= ST_ERR;
            r_expected <= lfsr_next(hif.lfsr_out);
          end else begin
            r_expected <= w_hit.shb ? 6'd0 : lfsr_next(hif.lfsr_out);
            if (r_state == ST_IDLE) r_state <= ST_TRACK;
          end
        end
      end
    end
  end

  assign hif.hsync   = r_hsync;
  assign hif.hblank  = r_hblank;
  assign hif.cburst  = r_cburst;
  assign hif.center  = r_center;
  assign hif.shb     = r_shb;
  assign hif.late_hb = r_late_hb;
  assign hif.seq_err = r_seq_err;
endmodule

`default_nettype wire

// File: tb/tb_tia_horizontal_decode.sv
// ============================================================================
// Module : tb_tia_horizontal_decode
// Brief  : Directed self-checking bench for the horizontal decode.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_tia_horizontal_decode;
  logic clk;
  logic rstl;
  int   checks;
  int   errors;

  tia_horizontal_decode_if hif ();

  tia_horizontal_decode #(.CHECK_SEQ(1'b1)) dut (
    .clk  (clk),
    .rstl (rstl),
    .hif  (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] obs;
  assign obs = {hif.hsync, hif.cburst, hif.hblank, hif.center, hif.shb, hif.late_hb, hif.seq_err};

  // Independent LFSR model: shift right, XNOR of the two low bits into bit 5
  function automatic logic [5:0] st(input int k);
    logic [5:0] s;
    s = 6'd0;
    for (int i = 0; i < k; i++) s = {~(s[1] ^ s[0]), s[5:1]};
    return s;
  endfunction

  // Expected {hsync,cburst,hblank,center,shb,late_hb,seq_err} after tick kk
  function automatic logic [6:0] line_exp(input int kk, input bit late, input bit lh, input bit err);
    int drop;
    drop = late ? 18 : 16;
    return {(kk >= 4 && kk <= 7), (kk >= 8 && kk <= 11), !(kk >= drop && kk <= 55),
            (kk == 36), (kk == 56), lh, err};
  endfunction

  task automatic drive(input logic en, input logic [5:0] v, input logic hm, input logic rs);
    @(negedge clk);
    hif.hclk_en   = en;
    hif.lfsr_out  = v;
    hif.hmove_stb = hm;
    hif.rsyn      = rs;
    @(posedge clk);
    #1;
    hif.hclk_en   = 1'b0;
    hif.hmove_stb = 1'b0;
    hif.rsyn      = 1'b0;
  endtask

  task automatic do_reset();
    hif.hclk_en = 1'b0; hif.lfsr_out = 6'd0; hif.hmove_stb = 1'b0; hif.rsyn = 1'b0;
    rstl = 1'b0;
    repeat (2) @(negedge clk);
    rstl = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== 7'b0010000) begin
      errors++;
      $display("FAIL reset_state got=%b want=%b", obs, 7'b0010000);
    end
  endtask

  task automatic test_legal_line();
    int n_shb, n_cnt, kk;
    n_shb = 0; n_cnt = 0;
    do_reset();
    for (int t = 0; t < 114; t++) begin
      kk = t % 57;
      drive(1'b1, st(kk), 1'b0, 1'b0);
      n_shb += int'(hif.shb);
      n_cnt += int'(hif.center);
      checks++;
      if (obs !== line_exp(kk, 0, 0, 0)) begin
        errors++;
        $display("FAIL legal_line k=%0d got=%b want=%b", kk, obs, line_exp(kk, 0, 0, 0));
      end
    end
    checks++;
    if (n_shb != 2 || n_cnt != 2) begin
      errors++;
      $display("FAIL pulse_count got shb=%0d center=%0d want 2/2", n_shb, n_cnt);
    end
  endtask

  task automatic test_hold();
    do_reset();
    for (int kk = 0; kk <= 4; kk++) drive(1'b1, st(kk), 1'b0, 1'b0);
    drive(1'b0, st(8), 1'b0, 1'b0);
    checks++;
    if (obs !== 7'b1010000) begin
      errors++;
      $display("FAIL hold_no_tick got=%b want=%b", obs, 7'b1010000);
    end
    drive(1'b0, st(36), 1'b0, 1'b0);
    checks++;
    if (obs !== 7'b1010000) begin
      errors++;
      $display("FAIL hold_no_center got=%b want=%b", obs, 7'b1010000);
    end
    drive(1'b1, st(5), 1'b0, 1'b0);
    checks++;
    if (obs !== line_exp(5, 0, 0, 0)) begin
      errors++;
      $display("FAIL hold_resume got=%b want=%b", obs, line_exp(5, 0, 0, 0));
    end
  endtask

  task automatic test_hmove();
    logic [6:0] e;
    do_reset();
    for (int kk = 0; kk <= 56; kk++) begin
      drive(1'b1, st(kk), kk == 2, 1'b0);
      e = line_exp(kk, 1, (kk >= 2 && kk <= 55), 0);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL hmove_line1 k=%0d got=%b want=%b", kk, obs, e);
      end
    end
    for (int kk = 0; kk <= 20; kk++) begin
      drive(1'b1, st(kk), 1'b0, 1'b0);
      e = line_exp(kk, 0, 0, 0);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL hmove_line2 k=%0d got=%b want=%b", kk, obs, e);
      end
    end
  endtask

  task automatic test_hmove_at_shb();
    logic [6:0] e;
    do_reset();
    for (int kk = 0; kk <= 56; kk++) begin
      drive(1'b1, st(kk), kk == 56, 1'b0);
      e = line_exp(kk, 0, kk == 56, 0);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL hmove_shb_line1 k=%0d got=%b want=%b", kk, obs, e);
      end
    end
    for (int kk = 0; kk <= 56; kk++) begin
      drive(1'b1, st(kk), 1'b0, 1'b0);
      e = line_exp(kk, 1, kk <= 55, 0);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL hmove_shb_line2 k=%0d got=%b want=%b", kk, obs, e);
      end
    end
  endtask

  task automatic test_rsync();
    logic [6:0] e;
    do_reset();
    for (int kk = 0; kk <= 29; kk++) drive(1'b1, st(kk), 1'b0, 1'b0);
    drive(1'b1, st(30), 1'b0, 1'b1);
    checks++;
    if (obs !== 7'b0010100) begin
      errors++;
      $display("FAIL rsyn_k30 got=%b want=%b", obs, 7'b0010100);
    end
    for (int kk = 0; kk <= 10; kk++) begin
      drive(1'b1, st(kk), 1'b0, 1'b0);
      e = line_exp(kk, 0, 0, 0);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL rsyn_restart k=%0d got=%b want=%b", kk, obs, e);
      end
    end
    // rsyn on the SHS tick: hsync must not rise
    do_reset();
    for (int kk = 0; kk <= 3; kk++) drive(1'b1, st(kk), 1'b0, 1'b0);
    drive(1'b1, st(4), 1'b0, 1'b1);
    checks++;
    if (obs !== 7'b0010100) begin
      errors++;
      $display("FAIL rsyn_priority got=%b want=%b", obs, 7'b0010100);
    end
    // rsyn with hmove in the same cycle keeps late_hb set
    drive(1'b0, 6'd0, 1'b1, 1'b1);
    checks++;
    if (obs !== 7'b0010110) begin
      errors++;
      $display("FAIL rsyn_hmove got=%b want=%b", obs, 7'b0010110);
    end
    for (int kk = 0; kk <= 20; kk++) begin
      drive(1'b1, st(kk), 1'b0, 1'b0);
      e = line_exp(kk, 1, 1, 0);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL rsyn_hmove_line k=%0d got=%b want=%b", kk, obs, e);
      end
    end
  endtask

  task automatic test_seq_err();
    logic [6:0] e;
    do_reset();
    for (int kk = 0; kk <= 19; kk++) drive(1'b1, st(kk), 1'b0, 1'b0);
    drive(1'b1, st(60), 1'b0, 1'b0);
    e = line_exp(19, 0, 0, 1);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL seq_err_rise got=%b want=%b", obs, e);
    end
    for (int kk = 21; kk <= 40; kk++) begin
      drive(1'b1, st(kk), 1'b0, 1'b0);
      e = line_exp(kk, 0, 0, 1);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL seq_err_sticky k=%0d got=%b want=%b", kk, obs, e);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int kk = 0; kk <= 5; kk++) drive(1'b1, st(kk), kk == 1, 1'b0);
    checks++;
    if (obs !== 7'b1010010) begin
      errors++;
      $display("FAIL pre_reset got=%b want=%b", obs, 7'b1010010);
    end
    #2;
    rstl = 1'b0;
    #1;
    checks++;
    if (obs !== 7'b0010000) begin
      errors++;
      $display("FAIL async_reset got=%b want=%b", obs, 7'b0010000);
    end
    @(negedge clk);
    rstl = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstl   = 1'b0;
    test_reset();
    test_legal_line();
    test_hold();
    test_hmove();
    test_hmove_at_shb();
    test_rsync();
    test_seq_err();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
